// File: rtl/imem_pkg.sv
// imem_pkg: shared FSM state type and bank/row address-split helpers for imem_banked.
package imem_pkg;

    typedef enum logic {INIT, RUN} state_t;

    function automatic int bank_shift(input int num_banks);
        return $clog2(num_banks);
    endfunction

    function automatic int bank_bits(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

    function automatic int row_bits(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/imem_bank.sv
// imem_bank: one row-addressed storage bank with byte-enabled write and registered read.
module imem_bank #(
    parameter int ROWS       = 64,
    parameter int RW         = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    Clock,
    input  logic                    rd_en,
    input  logic [RW-1:0]           rd_row,
    output logic [DATA_WIDTH-1:0]   rd_data,
    input  logic                    wr_en,
    input  logic [RW-1:0]           wr_row,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be
);

    logic [DATA_WIDTH-1:0] mem [ROWS];

    // Nonblocking read and write on the same edge give read-before-write.
    always_ff @(posedge Clock) begin
        if (rd_en) rd_data <= mem[rd_row];
        if (wr_en)
            for (int i = 0; i < DATA_WIDTH / 8; i++)
                if (wr_be[i]) mem[wr_row][8*i +: 8] <= wr_data[8*i +: 8];
    end

endmodule

// File: rtl/imem_banked.sv
// imem_banked: banked instruction memory with an init sweep, one-cycle fetch and a
// two-entry in-order response buffer.
module imem_banked
    import imem_pkg::*;
#(
    parameter int ADDR_BITS  = 8,
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BANKS  = 4,
    parameter int INIT_CLEAR = 1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_BITS-1:0]    req_addr,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    rsp_err,
    input  logic                    wr_en,
    input  logic [ADDR_BITS-1:0]    wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    output logic                    busy
);

    localparam int BS   = bank_shift(NUM_BANKS);
    localparam int BW   = bank_bits(NUM_BANKS);
    localparam int ROWS = DEPTH / NUM_BANKS;
    localparam int RW   = row_bits(ROWS);
    localparam int NBE  = DATA_WIDTH / 8;
    localparam logic [ADDR_BITS:0] LIMIT = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [BW-1:0] BMASK = BW'(NUM_BANKS - 1);

    state_t state_q, state_d;
    logic [RW-1:0] sweep_q, sweep_d;
    logic [1:0] cnt_q, cnt_d;
    logic err_q [2];
    logic err_d [2];
    logic live_q [2];
    logic live_d [2];
    logic [BW-1:0] bank_q [2];
    logic [BW-1:0] bank_d [2];
    logic [DATA_WIDTH-1:0] data_q [2];
    logic [DATA_WIDTH-1:0] data_d [2];
    logic [DATA_WIDTH-1:0] res [2];
    logic [DATA_WIDTH-1:0] rd_q [NUM_BANKS];

    logic run, push, pop, req_err, wr_hit, mem_we;
    logic [BW-1:0] req_bank, wr_bank;
    logic [RW-1:0] req_row, wr_row, mem_row;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NBE-1:0] mem_be;

    assign run       = state_q == RUN;
    assign busy      = !run;
    assign req_ready = run && cnt_q < 2'd2;
    assign push      = req_valid && req_ready;
    assign rsp_valid = cnt_q != 2'd0;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = rsp_valid ? res[0] : '0;
    assign rsp_err   = rsp_valid && err_q[0];

    assign req_err  = {1'b0, req_addr} >= LIMIT;
    assign req_bank = req_addr[BW-1:0] & BMASK;
    assign req_row  = RW'(req_addr >> BS);
    assign wr_hit   = {1'b0, wr_addr} < LIMIT;
    assign wr_bank  = wr_addr[BW-1:0] & BMASK;
    assign wr_row   = RW'(wr_addr >> BS);

    // During INIT the shared write port sweeps the same row of every bank with zeros.
    assign mem_we    = run ? (wr_en && wr_hit) : (INIT_CLEAR != 0);
    assign mem_row   = run ? wr_row : sweep_q;
    assign mem_wdata = run ? wr_data : '0;
    assign mem_be    = run ? wr_be : '1;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        imem_bank #(
            .ROWS(ROWS),
            .RW(RW),
            .DATA_WIDTH(DATA_WIDTH)
        ) u_bank (
            .Clock(Clock),
            .rd_en(push && !req_err && req_bank == BW'(b)),
            .rd_row(req_row),
            .rd_data(rd_q[b]),
            .wr_en(mem_we && (!run || wr_bank == BW'(b))),
            .wr_row(mem_row),
            .wr_data(mem_wdata),
            .wr_be(mem_be)
        );
    end

    // A live entry still reads straight from its bank's output register.
    always_comb begin
        for (int i = 0; i < 2; i++)
            res[i] = live_q[i] ? (err_q[i] ? '0 : rd_q[bank_q[i]]) : data_q[i];
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == INIT) begin
            if (INIT_CLEAR == 0 || sweep_q == RW'(ROWS - 1)) state_d = RUN;
            else sweep_d = sweep_q + RW'(1);
        end
    end

    // A new read overwrites a bank output, so live entries are frozen on every accept.
    always_comb begin
        err_d  = err_q;
        live_d = live_q;
        bank_d = bank_q;
        data_d = data_q;
        for (int i = 0; i < 2; i++) begin
            if (push && live_q[i]) begin
                data_d[i] = res[i];
                live_d[i] = 1'b0;
            end
        end
        if (pop) begin
            err_d[0]  = err_d[1];
            live_d[0] = live_d[1];
            bank_d[0] = bank_d[1];
            data_d[0] = data_d[1];
        end
        cnt_d = cnt_q - {1'b0, pop};
        if (push) begin
            err_d[cnt_d[0]]  = req_err;
            live_d[cnt_d[0]] = 1'b1;
            bank_d[cnt_d[0]] = req_bank;
            cnt_d            = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= INIT;
            sweep_q <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                err_q[i]  <= 1'b0;
                live_q[i] <= 1'b0;
                bank_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            live_q  <= live_d;
            bank_q  <= bank_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_imem_banked.sv
// tb_imem_banked: directed checks of imem_banked; instance a uses defaults, instance b
// uses DEPTH=200 to exercise the out-of-range path with the same stimulus.
module tb_imem_banked;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [7:0]  req_addr = '0;
    logic        rsp_ready = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;

    logic        a_req_ready, a_rsp_valid, a_rsp_err, a_busy;
    logic [31:0] a_rsp_data;
    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_busy;
    logic [31:0] b_rsp_data;

    int n_chk = 0;
    int n_fail = 0;
    int cyc;

    always #5 Clock = ~Clock;

    imem_banked u_a (
        .Clock(Clock), .Reset(Reset),
        .req_valid(req_valid), .req_ready(a_req_ready), .req_addr(req_addr),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(a_rsp_data), .rsp_err(a_rsp_err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .busy(a_busy)
    );

    imem_banked #(.DEPTH(200)) u_b (
        .Clock(Clock), .Reset(Reset),
        .req_valid(req_valid), .req_ready(b_req_ready), .req_addr(req_addr),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be = be;
        @(negedge Clock);
        wr_en = 1'b0;
    endtask

    // ea/eb are {err, data}; the response must be valid one edge after acceptance.
    task automatic fetch(input logic [7:0] a, input logic [32:0] ea, input logic [32:0] eb, input string tag);
        req_valid = 1'b1;
        req_addr = a;
        @(negedge Clock);
        req_valid = 1'b0;
        wr_en = 1'b0;
        chk({tag, "/a"}, 40'({a_rsp_valid, a_rsp_err, a_rsp_data}), 40'({1'b1, ea}));
        chk({tag, "/b"}, 40'({b_rsp_valid, b_rsp_err, b_rsp_data}), 40'({1'b1, eb}));
    endtask

    task automatic wait_sweep(input string tag);
        cyc = 0;
        while (a_busy && cyc < 200) begin
            chk({tag, "_ready_in_init"}, 40'(a_req_ready), 40'd0);
            if (cyc == 40) begin
                req_valid = 1'b0;
                wr_en = 1'b0;
            end
            @(negedge Clock);
            cyc++;
        end
        chk({tag, "_len"}, 40'(cyc), 40'd64);
    endtask

    initial begin
        @(negedge Clock);
        @(negedge Clock);
        chk("reset_a", 40'({a_busy, a_req_ready, a_rsp_valid, a_rsp_err, a_rsp_data}), 40'({4'b1000, 32'h0}));
        chk("reset_b", 40'({b_busy, b_req_ready, b_rsp_valid, b_rsp_err, b_rsp_data}), 40'({4'b1000, 32'h0}));

        // Requests and writes during INIT must have no effect.
        Reset = 1'b0;
        req_valid = 1'b1;
        req_addr = 8'h00;
        wr_en = 1'b1;
        wr_addr = 8'h40;
        wr_data = 32'hFFFF_FFFF;
        wr_be = 4'hF;
        wait_sweep("sweep");
        chk("run_a", 40'({a_busy, a_req_ready, a_rsp_valid}), 40'(3'b010));
        chk("run_b", 40'({b_busy, b_req_ready, b_rsp_valid}), 40'(3'b010));

        fetch(8'h00, 33'h0, 33'h0, "fetch00");
        fetch(8'h40, 33'h0, 33'h0, "init_wr_ignored");

        write(8'h10, 32'hDEAD_BEEF, 4'b1111);
        write(8'h10, 32'h0000_00AA, 4'b0001);
        fetch(8'h10, {1'b0, 32'hDEAD_BEAA}, {1'b0, 32'hDEAD_BEAA}, "byte_merge");

        write(8'h30, 32'hCAFE_F00D, 4'b0110);
        fetch(8'h30, {1'b0, 32'h00FE_F000}, {1'b0, 32'h00FE_F000}, "be_mid");

        wr_en = 1'b1;
        wr_addr = 8'h20;
        wr_data = 32'h1234_5678;
        wr_be = 4'hF;
        fetch(8'h20, 33'h0, 33'h0, "rbw_old");
        fetch(8'h20, {1'b0, 32'h1234_5678}, {1'b0, 32'h1234_5678}, "rbw_new");

        fetch(8'hC8, 33'h0, {1'b1, 32'h0}, "oor_read");
        write(8'hC8, 32'hFFFF_FFFF, 4'hF);
        fetch(8'hC8, {1'b0, 32'hFFFF_FFFF}, {1'b1, 32'h0}, "oor_write");
        fetch(8'hC7, 33'h0, 33'h0, "oor_neighbour");
        fetch(8'h10, {1'b0, 32'hDEAD_BEAA}, {1'b0, 32'hDEAD_BEAA}, "oor_no_alias");
        fetch(8'hFF, 33'h0, {1'b1, 32'h0}, "oor_top");

        // Back-pressure: two accepts fill the buffer, the head must hold.
        write(8'h01, 32'h1111_1111, 4'hF);
        write(8'h02, 32'h2222_2222, 4'hF);
        write(8'h03, 32'h3333_3333, 4'hF);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr = 8'h01;
        chk("bp_ready0", 40'(a_req_ready), 40'd1);
        @(negedge Clock);
        req_addr = 8'h02;
        chk("bp_first", 40'({a_rsp_valid, a_req_ready, a_rsp_data}), 40'({2'b11, 32'h1111_1111}));
        @(negedge Clock);
        req_addr = 8'h03;
        chk("bp_full", 40'({a_rsp_valid, a_req_ready, a_rsp_data}), 40'({2'b10, 32'h1111_1111}));
        @(negedge Clock);
        chk("bp_hold", 40'({a_rsp_valid, a_req_ready, a_rsp_data}), 40'({2'b10, 32'h1111_1111}));
        rsp_ready = 1'b1;
        @(negedge Clock);
        chk("bp_second", 40'({a_rsp_valid, a_req_ready, a_rsp_data}), 40'({2'b11, 32'h2222_2222}));
        @(negedge Clock);
        req_valid = 1'b0;
        chk("bp_third", 40'({a_rsp_valid, a_rsp_data}), 40'({1'b1, 32'h3333_3333}));
        chk("bp_third_b", 40'({b_rsp_valid, b_rsp_data}), 40'({1'b1, 32'h3333_3333}));
        @(negedge Clock);
        chk("bp_drained", 40'(a_rsp_valid), 40'd0);

        // Reset with two responses pending.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr = 8'h01;
        @(negedge Clock);
        req_addr = 8'h02;
        @(negedge Clock);
        req_valid = 1'b0;
        chk("pend_full", 40'({a_rsp_valid, a_req_ready}), 40'(2'b10));
        Reset = 1'b1;
        #1;
        chk("async_rst_a", 40'({a_busy, a_req_ready, a_rsp_valid, a_rsp_err, a_rsp_data}), 40'({4'b1000, 32'h0}));
        chk("async_rst_b", 40'({b_busy, b_req_ready, b_rsp_valid, b_rsp_err, b_rsp_data}), 40'({4'b1000, 32'h0}));
        @(negedge Clock);
        Reset = 1'b0;
        rsp_ready = 1'b1;
        wait_sweep("resweep");
        repeat (3) @(negedge Clock);
        chk("no_stale_a", 40'(a_rsp_valid), 40'd0);
        chk("no_stale_b", 40'(b_rsp_valid), 40'd0);
        fetch(8'h01, 33'h0, 33'h0, "cleared01");
        fetch(8'h10, 33'h0, 33'h0, "cleared10");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_banked.md
IMEM_BANKED -- requirements
Module: imem_banked

Interface
REQ-001 Parameter ADDR_BITS, default 8, SHALL be the word-address width.
REQ-002 Parameter DEPTH, default 256, SHALL be the number of implemented words; DEPTH ≤ 2^ADDR_BITS and DEPTH is a multiple of NUM_BANKS.
REQ-003 Parameter DATA_WIDTH, default 32, SHALL be the word width; it is a multiple of 8.
REQ-004 Parameter NUM_BANKS, default 4, SHALL be the bank count; it is a power of two, ≥1.
REQ-005 Parameter INIT_CLEAR, default 1, SHALL enable the post-reset zeroing sweep.
REQ-006 Ports SHALL be (name direction width meaning):
- Clock  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- req_valid  in  1  fetch request valid
- req_ready  out  1  fetch request accepted when both high
- req_addr  in  ADDR_BITS  fetch word address
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when both high
- rsp_data  out  DATA_WIDTH  fetched word
- rsp_err  out  1  fetched address ≥ DEPTH
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_BITS  write word address
- wr_data  in  DATA_WIDTH  write data
- wr_be  in  DATA_WIDTH/8  byte enables, bit i covers bits 8i+7:8i
- busy  out  1  init sweep in progress

Function
REQ-007 Bank SHALL be addr[log2(NUM_BANKS)-1:0]; row SHALL be the remaining upper bits.
REQ-008 FSM SHALL have states INIT and RUN; INIT → RUN after the sweep completes; RUN has no exit except Reset.
REQ-009 INIT with INIT_CLEAR=1: one row per cycle zeroed in all banks, DEPTH/NUM_BANKS cycles, busy=1; then RUN.
REQ-010 INIT with INIT_CLEAR=0: exactly one cycle, busy=1, contents unchanged; then RUN.
REQ-011 In INIT, req_ready SHALL be 0 and wr_en SHALL be ignored.
REQ-012 Occupancy = requests in flight + responses held; maximum 2.
REQ-013 req_ready SHALL be 1 iff state=RUN and occupancy<2; no combinational path from rsp_ready to req_ready.
REQ-014 Read latency SHALL be one cycle: a request accepted at edge N is presentable on rsp_* after edge N+1.
REQ-015 Responses SHALL be returned in request order via a 2-entry output buffer; rsp_data/rsp_err SHALL be held stable while rsp_valid=1 and rsp_ready=0.
REQ-016 Sustained throughput SHALL be one fetch per cycle when rsp_ready=1.
REQ-017 req_addr ≥ DEPTH SHALL return rsp_err=1, rsp_data=0; no array access.
REQ-018 Write in RUN SHALL update only bytes whose wr_be bit is 1; wr_addr ≥ DEPTH SHALL be ignored.
REQ-019 Read and write to the same address accepted in the same cycle SHALL return the old data (read-before-write).
REQ-020 Unaccepted requests (req_ready=0) SHALL have no effect.

Reset
REQ-021 Reset SHALL asynchronously force: state=INIT, busy=1, req_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, occupancy=0, sweep counter=0.
REQ-022 Reset mid-operation SHALL discard in-flight and buffered responses; memory contents are defined only after the sweep (INIT_CLEAR=1).

Structure
REQ-023 Package imem_pkg SHALL hold the state enum (INIT, RUN) and a bank/row split helper constant set.
REQ-024 One sub-module imem_bank (one row-addressed storage bank, byte-enabled write, synchronous read) SHALL be instantiated NUM_BANKS times.

Verification
REQ-025 Reset released, INIT_CLEAR=1, defaults -> busy=1 for 64 cycles, then req_ready=1; fetch 0x00 -> rsp_data=0x00000000.
REQ-026 Write 0x10 data 0xDEADBEEF be=4'b1111, then write 0x10 data 0x000000AA be=4'b0001, fetch 0x10 -> 0xDEADBEAA.
REQ-027 Same cycle write 0x20=0x12345678 and fetch 0x20 (previously 0) -> rsp_data=0; next fetch 0x20 -> 0x12345678.
REQ-028 DEPTH=200, fetch 0xC8 -> rsp_err=1, rsp_data=0; write 0xC8 -> no change at any address.
REQ-029 Fetch 0x01,0x02,0x03 back-to-back, rsp_ready=0 for 3 cycles -> req_ready drops after 2 accepts, rsp_data held at word 0x01; rsp_ready=1 -> 0x01,0x02,0x03 in order.
REQ-030 Reset asserted with 2 responses pending -> rsp_valid=0 immediately, busy=1; after sweep no stale response appears.
